// File: rtl/trunc_arbiter.sv
// trunc_arbiter: round-robin burst arbiter sharing one truncation datapath between two DCT passes.
// Build option: define TRUNC_ROUND_EN for round-half-up with positive saturation instead of plain truncation.
module trunc_arbiter #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 8,
  parameter int BURST     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  input  logic [WIDTH_IN-1:0]  req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WIDTH_IN-1:0]  req1_data,
  output logic                 req1_ready,
  output logic                 out_valid,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic                 out_src,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int SHIFT = WIDTH_IN - WIDTH_OUT;
  localparam int CW    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic                 ptr;
  logic                 out_free;
  logic                 accept0;
  logic                 accept1;
  logic                 accept;
  logic [WIDTH_IN-1:0]  sel_data;
  logic [WIDTH_OUT-1:0] shrunk;

  if (WIDTH_IN <= WIDTH_OUT || BURST < 1) begin : g_param_check
    $error("trunc_arbiter: requires WIDTH_IN > WIDTH_OUT and BURST >= 1");
  end

  // The output slot is free when empty or being drained this cycle.
  assign out_free   = !out_valid || out_ready;
  assign req0_ready = (state == GRANT0) && out_free;
  assign req1_ready = (state == GRANT1) && out_free;
  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;
  assign accept     = accept0 || accept1;
  assign sel_data   = (state == GRANT1) ? req1_data : req0_data;

`ifdef TRUNC_ROUND_EN
  localparam logic [WIDTH_IN:0] HALF = {{WIDTH_IN{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [WIDTH_IN:0] rounded;
  logic              unused_round;

  assign rounded      = {sel_data[WIDTH_IN-1], sel_data} + HALF;
  assign unused_round = ^rounded[SHIFT-1:0];

  // Adding the half LSB can only overflow upward; clamp that case to the largest positive code.
  always_comb begin
    shrunk = rounded[WIDTH_IN-1:SHIFT];
    if (!rounded[WIDTH_IN] && rounded[WIDTH_IN-1])
      shrunk = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  end
`else
  logic unused_low;

  assign unused_low = ^sel_data[SHIFT-1:0];
  assign shrunk     = sel_data[WIDTH_IN-1:SHIFT];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      ptr       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid && (!req1_valid || !ptr))
            state <= GRANT0;
          else if (req1_valid)
            state <= GRANT1;
        end
        GRANT0, GRANT1: begin
          if (accept) begin
            if (count == LAST_BEAT) begin
              count <= '0;
              state <= IDLE;
              ptr   <= (state == GRANT0);
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A new beat overwrites the slot even while the old one drains, keeping 1 sample/cycle.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= shrunk;
        out_src   <= (state == GRANT1);
        out_last  <= (count == LAST_BEAT);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trunc_arbiter.sv
// tb_trunc_arbiter: directed, table-driven bench for trunc_arbiter (WIDTH_IN=16, WIDTH_OUT=8, BURST=8).
module tb_trunc_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_src, out_last, out_ready;
  logic [7:0]  out_data;

  trunc_arbiter #(.WIDTH_IN(16), .WIDTH_OUT(8), .BURST(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [15:0] d0;
    logic       ordy;
    logic       e_r0;
    logic       e_r1;
    logic       e_ov;
    logic [7:0] e_d;
    logic       e_last;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       src;
    logic       last;
  } beat_t;

  typedef struct {
    logic [15:0] sample;
    logic [7:0]  e_trunc;
    logic [7:0]  e_round;
  } sign_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  vec_t  vecs [11];
  sign_t signs [8];
  beat_t exp_q [$];

  logic [15:0] pat0 [32];
  logic [15:0] pat1 [32];
  int          idx0, idx1, n0, n1;
  logic        en0, en1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] topByte(input logic [15:0] d);
    logic [15:0] t;
    t = d;
    return t[15:8];
  endfunction

  task automatic pushExp(input logic [7:0] d, input logic s, input logic l);
    beat_t b;
    b.data = d;
    b.src  = s;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic driveSources();
    req0_valid = en0 && (idx0 < n0);
    req1_valid = en1 && (idx1 < n1);
    req0_data  = req0_valid ? pat0[idx0] : 16'h0;
    req1_data  = req1_valid ? pat1[idx1] : 16'h0;
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid = v.v0;
    req0_data  = v.d0;
    req1_valid = 1'b0;
    req1_data  = 16'h0;
    out_ready  = v.ordy;
  endtask

  // One clock of source-driven traffic: score the output handshake, then advance sources that were accepted.
  task automatic cycle();
    logic  acc0, acc1;
    beat_t b;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 32'd1, 32'd0);
      end else begin
        b = exp_q.pop_front();
        checkOutput("beat_data", 32'(out_data), 32'(b.data));
        checkOutput("beat_src", 32'(out_src), 32'(b.src));
        checkOutput("beat_last", 32'(out_last), 32'(b.last));
      end
    end
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (acc0 && reset_n) idx0++;
    if (acc1 && reset_n) idx1++;
    driveSources();
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runUntilEmpty(input string name, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      cycle();
      c++;
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int   done_cycle;
    logic stalled;

    // Single req0 burst, cycle by cycle: bubble, 8 beats, drain.
    for (int k = 0; k < 9; k++) begin
      vecs[k].v0     = 1'b1;
      vecs[k].d0     = 16'h1234 + 16'((k > 0 ? k - 1 : 0) * 16'h0100);
      vecs[k].ordy   = 1'b1;
      vecs[k].e_r0   = (k >= 1);
      vecs[k].e_r1   = 1'b0;
      vecs[k].e_ov   = (k >= 2);
      vecs[k].e_d    = (k >= 2) ? 8'(8'h12 + k - 2) : 8'h00;
      vecs[k].e_last = 1'b0;
    end
    vecs[9]  = '{v0: 1'b0, d0: 16'h0, ordy: 1'b1, e_r0: 1'b0, e_r1: 1'b0, e_ov: 1'b1, e_d: 8'h19, e_last: 1'b1};
    vecs[10] = '{v0: 1'b0, d0: 16'h0, ordy: 1'b1, e_r0: 1'b0, e_r1: 1'b0, e_ov: 1'b0, e_d: 8'h19, e_last: 1'b1};

    signs[0] = '{16'hFF80, 8'hFF, 8'h00};
    signs[1] = '{16'h8000, 8'h80, 8'h80};
    signs[2] = '{16'h7FFF, 8'h7F, 8'h7F};
    signs[3] = '{16'h0080, 8'h00, 8'h01};
    signs[4] = '{16'h007F, 8'h00, 8'h00};
    signs[5] = '{16'h7FF0, 8'h7F, 8'h7F};
    signs[6] = '{16'h0000, 8'h00, 8'h00};
    signs[7] = '{16'hC0C0, 8'hC0, 8'hC1};

    en0 = 1'b0; en1 = 1'b0; idx0 = 0; idx1 = 0; n0 = 0; n1 = 0;
    req0_valid = 1'b1; req0_data = 16'h1234;
    req1_valid = 1'b1; req1_data = 16'h5678;
    out_ready  = 1'b1;

    // Reset values, with both requesters asserting valid.
    doReset();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_src", 32'(out_src), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
    reset_n = 1'b1;

    for (int k = 0; k < 11; k++) begin
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("t1_req0_ready[%0d]", k), 32'(req0_ready), 32'(vecs[k].e_r0));
      checkOutput($sformatf("t1_req1_ready[%0d]", k), 32'(req1_ready), 32'(vecs[k].e_r1));
      checkOutput($sformatf("t1_out_valid[%0d]", k), 32'(out_valid), 32'(vecs[k].e_ov));
      checkOutput($sformatf("t1_out_data[%0d]", k), 32'(out_data), 32'(vecs[k].e_d));
      checkOutput($sformatf("t1_out_src[%0d]", k), 32'(out_src), 32'd0);
      checkOutput($sformatf("t1_out_last[%0d]", k), 32'(out_last), 32'(vecs[k].e_last));
      @(posedge clk);
      #1;
    end

    // Both requesters valid from reset: r0 x8, bubble, r1 x8, bubble, r0 x8.
    for (int i = 0; i < 16; i++) pat0[i] = 16'h1034 + 16'(i * 16'h0100);
    for (int i = 0; i < 8; i++)  pat1[i] = 16'h5034 + 16'(i * 16'h0100);
    en0 = 1'b1; en1 = 1'b1; n0 = 16; n1 = 8; idx0 = 0; idx1 = 0;
    out_ready = 1'b1;
    driveSources();
    doReset();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) pushExp(topByte(pat0[i]), 1'b0, i == 7);
    for (int i = 0; i < 8; i++) pushExp(topByte(pat1[i]), 1'b1, i == 7);
    for (int i = 8; i < 16; i++) pushExp(topByte(pat0[i]), 1'b0, i == 15);
    done_cycle = -1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (exp_q.size() == 0 && done_cycle < 0) done_cycle = c;
    end
    checkOutput("t2_done_cycle", 32'(done_cycle), 32'd27);

    // Sign handling through a req0 burst.
    en1 = 1'b0; n1 = 0; idx0 = 0; n0 = 8;
    for (int i = 0; i < 8; i++) begin
      pat0[i] = signs[i].sample;
`ifdef TRUNC_ROUND_EN
      pushExp(signs[i].e_round, 1'b0, i == 7);
`else
      pushExp(signs[i].e_trunc, 1'b0, i == 7);
`endif
    end
    driveSources();
    runUntilEmpty("t4_sign_drained", 40);

    // Backpressure: three stalled cycles after beat 3.
    idx0 = 0;
    for (int i = 0; i < 8; i++) begin
      pat0[i] = 16'h2034 + 16'(i * 16'h0100);
      pushExp(topByte(pat0[i]), 1'b0, i == 7);
    end
    driveSources();
    stalled = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      cycle();
      if (idx0 == 3 && !stalled) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          checkOutput($sformatf("t3_stall_ready[%0d]", s), 32'(req0_ready), 32'd0);
          checkOutput($sformatf("t3_stall_valid[%0d]", s), 32'(out_valid), 32'd1);
          checkOutput($sformatf("t3_stall_data[%0d]", s), 32'(out_data), 32'h22);
          checkOutput($sformatf("t3_stall_last[%0d]", s), 32'(out_last), 32'd0);
          cycle();
        end
        out_ready = 1'b1;
      end
    end
    checkOutput("t3_stalled", 32'(stalled), 32'd1);
    checkOutput("t3_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t3_accepted", 32'(idx0), 32'd8);

    // Reset in the middle of a req1 burst, both requesters valid afterwards.
    en0 = 1'b0; en1 = 1'b1; n1 = 8; idx1 = 0;
    for (int i = 0; i < 8; i++) begin
      pat0[i] = 16'h3034 + 16'(i * 16'h0100);
      pat1[i] = 16'h4034 + 16'(i * 16'h0100);
    end
    for (int i = 0; i < 3; i++) pushExp(topByte(pat1[i]), 1'b1, 1'b0);
    driveSources();
    for (int c = 0; c < 20 && idx1 < 3; c++) cycle();
    checkOutput("t6_reached_beat3", 32'(idx1), 32'd3);
    en0 = 1'b1;
    reset_n = 1'b0;
    driveSources();
    cycle();
    reset_n = 1'b1;
    idx0 = 0; idx1 = 0;
    driveSources();
    #1;
    checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("t6_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("t6_partial_flushed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) pushExp(topByte(pat0[i]), 1'b0, i == 7);
    for (int i = 0; i < 8; i++) pushExp(topByte(pat1[i]), 1'b1, i == 7);
    runUntilEmpty("t6_drained", 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
